// File: rtl/uart_parity_gen.sv
// uart_parity_gen: registered parity generator for the UART TX path.
// Samples a data word, parity type and word length on a load strobe. One
// clock later it presents the parity bit and the parity enable, and pulses
// parity_valid for that cycle.
// Optional receive-side check is built only when PARITY_CHECK_EN is defined:
// this adds the rx_parity input and the registered parity_err output.
module uart_parity_gen #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [1:0]            parity_type,
  input  logic [1:0]            data_len,
`ifdef PARITY_CHECK_EN
  input  logic                  rx_parity,
  output logic                  parity_err,
`endif
  output logic                  parity_bit,
  output logic                  parity_en,
  output logic                  parity_valid
);

  typedef enum logic [1:0] {
    PAR_NONE0 = 2'b00,
    PAR_ODD   = 2'b01,
    PAR_EVEN  = 2'b10,
    PAR_NONE3 = 2'b11
  } par_type_e;

  // Selects the active low bits. L = min(5 + len, DATA_WIDTH).
  function automatic logic [DATA_WIDTH-1:0] len_mask(input logic [1:0] len);
    logic [DATA_WIDTH-1:0] m;
    int active;
    m      = '0;
    active = 5 + int'(len);
    if (active > DATA_WIDTH) active = DATA_WIDTH;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      m[i] = (i < active);
    end
    return m;
  endfunction

  // Returns 1 when the parity type selects odd or even parity.
  function automatic logic type_has_parity(input par_type_e t);
    return (t == PAR_ODD) || (t == PAR_EVEN);
  endfunction

  // Converts the XOR reduction of the word into the parity bit on the line.
  // When no parity is selected, the bit is held at the idle level (1).
  function automatic logic parity_of(input par_type_e t, input logic ones);
    logic p;
    case (t)
      PAR_ODD:  p = ~ones;
      PAR_EVEN: p = ones;
      default:  p = 1'b1;
    endcase
    return p;
  endfunction

  // ---- stage p0: combinational evaluation of the inputs being loaded ----
  par_type_e             type_p0;
  logic [DATA_WIDTH-1:0] word_p0;
  logic                  ones_p0;
  logic                  bit_p0;
  logic                  en_p0;

  // Masks the word to its active length and reduces it to the parity bit.
  always_comb begin
    type_p0 = par_type_e'(parity_type);
    word_p0 = data_in & len_mask(data_len);
    ones_p0 = ^word_p0;
    bit_p0  = parity_of(type_p0, ones_p0);
    en_p0   = type_has_parity(type_p0);
  end

  // ---- stage p1: registered result presented to the framer ----
  par_type_e type_p1;
  logic      bit_p1;
  logic      vld_p1;

  // Captures the result on load and pulses valid for one cycle per load.
  // When load is low, the captured result is held.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      type_p1 <= PAR_NONE0;
      bit_p1  <= 1'b1;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= load;
      if (load) begin
        type_p1 <= type_p0;
        bit_p1  <= bit_p0;
      end
    end
  end

  assign parity_bit   = bit_p1;
  assign parity_en    = type_has_parity(type_p1);
  assign parity_valid = vld_p1;

`ifdef PARITY_CHECK_EN
  logic err_p1;

  // Flags a mismatch between the received parity bit and the computed one.
  // The flag is raised only when parity is enabled for the loaded type.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_p1 <= 1'b0;
    end else if (load) begin
      err_p1 <= en_p0 && (rx_parity != bit_p0);
    end
  end

  assign parity_err = err_p1;
`endif

endmodule

// File: tb/tb_uart_parity_gen.sv
// tb_uart_parity_gen: directed-vector bench for uart_parity_gen.
// Expected values are hand-computed from the vectors.
// Define PARITY_CHECK_EN to also exercise the receive-side check.
module tb_uart_parity_gen;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       load;
  logic [7:0] data_in;
  logic [1:0] parity_type;
  logic [1:0] data_len;
  logic       parity_bit;
  logic       parity_en;
  logic       parity_valid;
`ifdef PARITY_CHECK_EN
  logic       rx_parity;
  logic       parity_err;
`endif

  int checks = 0;
  int errors = 0;

  uart_parity_gen #(.DATA_WIDTH(8)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .load         (load),
    .data_in      (data_in),
    .parity_type  (parity_type),
    .data_len     (data_len),
`ifdef PARITY_CHECK_EN
    .rx_parity    (rx_parity),
    .parity_err   (parity_err),
`endif
    .parity_bit   (parity_bit),
    .parity_en    (parity_en),
    .parity_valid (parity_valid)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sets the inputs at a negedge so that load is sampled at the next posedge.
  // Sampling happens 1 time unit after that edge.
  task automatic load_word(input logic [7:0] d, input logic [1:0] t, input logic [1:0] len);
    @(negedge clock);
    load = 1'b1; data_in = d; parity_type = t; data_len = len;
    @(posedge clock); #1;
  endtask

  task automatic idle_cycle();
    @(negedge clock);
    load = 1'b0;
    @(posedge clock); #1;
  endtask

  // Checks the outputs one clock after a load, and that valid drops on the next cycle.
  task automatic expect_result(input string tag, input logic b, input logic e);
    check({tag, "_valid"}, parity_valid, 1'b1);
    check({tag, "_bit"},   parity_bit,   b);
    check({tag, "_en"},    parity_en,    e);
    idle_cycle();
    check({tag, "_vld_off"}, parity_valid, 1'b0);
    check({tag, "_hold"},    parity_bit,   b);
  endtask

  initial begin
    reset_n = 1'b0; load = 1'b0; data_in = '0; parity_type = 2'b00; data_len = 2'b11;
`ifdef PARITY_CHECK_EN
    rx_parity = 1'b0;
`endif
    #12;
    check("rst_bit",   parity_bit,   1'b1);
    check("rst_en",    parity_en,    1'b0);
    check("rst_valid", parity_valid, 1'b0);
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;
    check("idle_valid", parity_valid, 1'b0);

    // 8-bit odd and even parity
    load_word(8'h17, 2'b01, 2'b11); expect_result("odd_17",  1'b1, 1'b1);
    load_word(8'hA9, 2'b10, 2'b11); expect_result("even_A9", 1'b0, 1'b1);
    // no parity: types 00 and 11
    load_word(8'h0F, 2'b00, 2'b11); expect_result("none_0F", 1'b1, 1'b0);
    load_word(8'hBD, 2'b11, 2'b11); expect_result("none_BD", 1'b1, 1'b0);
    // word length masking
    load_word(8'hAF, 2'b01, 2'b11); expect_result("odd_AF_8",  1'b1, 1'b1);
    load_word(8'hAF, 2'b01, 2'b10); expect_result("odd_AF_7",  1'b0, 1'b1);
    load_word(8'hAF, 2'b10, 2'b10); expect_result("even_AF_7", 1'b1, 1'b1);
    load_word(8'hE0, 2'b10, 2'b00); expect_result("even_E0_5", 1'b0, 1'b1);
    load_word(8'h3F, 2'b10, 2'b01); expect_result("even_3F_6", 1'b0, 1'b1);
    load_word(8'h20, 2'b01, 2'b00); expect_result("odd_20_5",  1'b1, 1'b1);

    // back-to-back loads on consecutive cycles
    load_word(8'h01, 2'b10, 2'b11);
    check("b2b1_valid", parity_valid, 1'b1);
    check("b2b1_bit",   parity_bit,   1'b1);
    load_word(8'h03, 2'b10, 2'b11);
    check("b2b2_valid", parity_valid, 1'b1);
    check("b2b2_bit",   parity_bit,   1'b0);
    // hold: inputs change without load
    @(negedge clock);
    load = 1'b0; data_in = 8'hFE; parity_type = 2'b00;
    repeat (3) @(posedge clock); #1;
    check("hold_bit",   parity_bit,   1'b0);
    check("hold_en",    parity_en,    1'b1);
    check("hold_valid", parity_valid, 1'b0);

    // async reset with a load pending; outputs were bit=0 en=1 before
    @(negedge clock);
    load = 1'b1; data_in = 8'h17; parity_type = 2'b10; data_len = 2'b11;
    #2 reset_n = 1'b0;
    #1;
    check("arst_bit",   parity_bit,   1'b1);
    check("arst_en",    parity_en,    1'b0);
    check("arst_valid", parity_valid, 1'b0);
    @(negedge clock); load = 1'b0;
    @(negedge clock); reset_n = 1'b1;
    repeat (2) begin
      @(posedge clock); #1;
      check("post_rst_valid", parity_valid, 1'b0);
    end
    check("post_rst_bit", parity_bit, 1'b1);

    // reset release with load high in the same cycle
    @(negedge clock); reset_n = 1'b0;
    @(negedge clock);
    load = 1'b1; data_in = 8'hA9; parity_type = 2'b10; data_len = 2'b11;
    reset_n = 1'b1;
    @(posedge clock); #1;
    expect_result("rel_load", 1'b0, 1'b1);

`ifdef PARITY_CHECK_EN
    rx_parity = 1'b1;
    load_word(8'h17, 2'b10, 2'b11);
    check("err_mismatch", parity_err, 1'b1);
    @(negedge clock); load = 1'b0; rx_parity = 1'b0;
    @(posedge clock); #1;
    check("err_hold", parity_err, 1'b1);
    load_word(8'h17, 2'b10, 2'b11);
    check("err_match", parity_err, 1'b0);
    rx_parity = 1'b1;
    load_word(8'h17, 2'b00, 2'b11);
    check("err_none_rx1", parity_err, 1'b0);
    rx_parity = 1'b0;
    load_word(8'h17, 2'b11, 2'b11);
    check("err_none_rx0", parity_err, 1'b0);
    rx_parity = 1'b0;
    load_word(8'h17, 2'b01, 2'b11);
    check("err_odd_mismatch", parity_err, 1'b1);
    @(negedge clock); load = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_parity_gen.md
Name: uart_parity_gen

Overview:
- Registered parity generator for the UART transmitter path.
- Samples a data word on a load strobe and computes odd, even or no parity over the active word length (5 to 8 bits).
- Presents the parity bit to the TX framer one clock later.
- Sits between the TX holding register and the TX shift/frame logic.

Parameters:
DATA_WIDTH, 8, maximum data word width in bits; the word length (data_len) selects the active bits within this width.

Ports:
clock  input  1  system clock, rising-edge active
reset_n  input  1  asynchronous active-low reset
load  input  1  1-cycle strobe: sample data_in/parity_type/data_len and compute parity
data_in  input  DATA_WIDTH  data word; bit 0 is LSB
parity_type  input  2  00 = none, 01 = odd, 10 = even, 11 = none
data_len  input  2  active bits: 00 = 5, 01 = 6, 10 = 7, 11 = 8; bits above the active length are ignored
parity_bit  output  1  registered parity bit
parity_en  output  1  registered; 1 when the latched parity_type is odd or even
parity_valid  output  1  1-cycle pulse: parity_bit/parity_en updated

Behaviour:
- Reset (reset_n low, asynchronous):
  - parity_bit = 1 (line idle level), parity_en = 0, parity_valid = 0.
  - Internal latched type = none.
  - Reset mid-operation discards a pending computation; no valid pulse follows.
- Masking:
  - Active bits are data_in[L-1:0], where L = 5 + data_len.
  - Upper bits are masked to 0 before reduction.
  - Width rule: L = min(5 + data_len, DATA_WIDTH).
- Computation:
  - ones = XOR-reduce of the masked word.
  - Odd (01): parity_bit = ~ones, so total ones including the parity bit is odd.
  - Even (10): parity_bit = ones.
  - None (00 or 11): parity_bit = 1, parity_en = 0.
- Latency:
  - load sampled high at edge N: parity_bit, parity_en updated and parity_valid = 1 after edge N.
  - parity_valid deasserts after edge N+1 unless load is high again.
- Back-to-back loads:
  - Every load computes a fresh result.
  - Consecutive cycles give consecutive valid pulses; parity_valid stays high.
- Hold: with load low, parity_bit/parity_en hold their last value indefinitely. Changes on data_in or parity_type without load have no effect.
- Reset release with load high in the same cycle: the first rising edge with reset_n high samples normally.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: PARITY_CHECK_EN.
- When defined, adds two ports:
  - rx_parity (input, 1): received parity bit, sampled with load.
  - parity_err (output, 1, registered, reset 0).
- parity_err behaviour:
  - Updated with parity_valid.
  - 1 when parity_en would be 1 and rx_parity differs from the computed parity_bit; otherwise 0.
  - Holds until the next load.
- When not defined: neither port exists and no check logic is built.

Test Plan:
- Reset: assert reset_n = 0 mid-run with a load pending -> parity_bit = 1, parity_en = 0, parity_valid = 0 immediately (asynchronous); no valid pulse after release.
- 8-bit word, odd/even (data_len = 11):
  - load 0x17, type 01 -> parity_bit = 1, parity_en = 1, valid one clock after load.
  - load 0xA9, type 10 -> parity_bit = 0.
- No parity, data_len = 11:
  - load 0x0F, type 00 -> parity_bit = 1, parity_en = 0.
  - load 0xBD, type 11 -> parity_bit = 1, parity_en = 0.
- Word length:
  - load 0xAF, type 01, data_len = 11 -> 1; same with data_len = 10 (7 bits, five ones) -> 0.
  - type 10, data_len = 10 -> 1.
  - load 0xE0, data_len = 00, type 10 -> 0 (upper bits masked).
- Back-to-back / hold:
  - load 0x01 then 0x03 on consecutive cycles (type 10) -> parity_bit 1 then 0, parity_valid high both cycles.
  - Then change data_in without load -> outputs unchanged.
- PARITY_CHECK_EN:
  - load 0x17, type 10, rx_parity = 1 -> parity_err = 1.
  - rx_parity = 0 -> parity_err = 0.
  - type 00, any rx_parity -> parity_err = 0.
